// File: rtl/cmp_branch_if.sv
// Bundle between the execute-stage ALU / branch issue logic and cmp_branch_unit.
//   master : ALU flag source and branch requester (drives ex_valid, alu_op, comp_flag,
//            flag_clr, br_valid, br_cond, br_target; observes the rest)
//   slave  : cmp_branch_unit (returns br_ready, flag_reg, flag_valid, redirect,
//            redirect_pc, flush)
interface cmp_branch_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              ex_valid;
   logic [3:0]        alu_op;
   logic [9:0]        comp_flag;
   logic              flag_clr;
   logic              br_valid;
   logic              br_ready;
   logic [3:0]        br_cond;
   logic [ADDR_W-1:0] br_target;
   logic [9:0]        flag_reg;
   logic              flag_valid;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;

   modport master (
      output ex_valid, alu_op, comp_flag, flag_clr, br_valid, br_cond, br_target,
      input  br_ready, flag_reg, flag_valid, redirect, redirect_pc, flush
   );

   modport slave (
      input  ex_valid, alu_op, comp_flag, flag_clr, br_valid, br_cond, br_target,
      output br_ready, flag_reg, flag_valid, redirect, redirect_pc, flush
   );
endinterface

// File: rtl/cmp_branch_unit.sv
// Compare-flag register and conditional branch resolver.
// Captures the ALU's 10-bit compare flags on CMP, resolves branches against stored or
// same-cycle bypassed flags over a valid/ready handshake, and on a taken branch issues a
// one-cycle PC redirect followed by a flush lasting FLUSH_CYCLES cycles in total.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cmp_branch_if slave (flag capture inputs, branch handshake, redirect/flush)
module cmp_branch_unit #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [3:0]  CMP_OP       = 4'b0111
) (
   input logic        clk,
   input logic        rst_n,
   cmp_branch_if.slave bus
);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StRedirect = 2'd1;
   localparam logic [1:0] StFlush    = 2'd2;

   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [9:0]        flag_reg_q, flag_reg_d;
   logic              flag_valid_q, flag_valid_d;
   logic              redirect_q, redirect_d;
   logic              flush_q, flush_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

   logic       cmp_hit;
   logic [9:0] eff_flags;
   logic       eff_ok;
   logic       needs_flags;
   logic       br_ready;
   logic       taken;

   // Flags from a CMP in the same cycle bypass the register.
   always_comb begin
      cmp_hit     = bus.ex_valid && (bus.alu_op == CMP_OP);
      eff_flags   = cmp_hit ? bus.comp_flag : flag_reg_q;
      eff_ok      = cmp_hit ? 1'b1 : flag_valid_q;
      needs_flags = (bus.br_cond <= 4'd9);
      // Gated by rst_n so the requester sees no acceptance while reset is held.
      br_ready    = rst_n && (state_q == StIdle) && (!needs_flags || eff_ok);
      taken       = needs_flags ? eff_flags[bus.br_cond] : (bus.br_cond == 4'd10);
   end

   always_comb begin
      flag_reg_d    = flag_reg_q;
      flag_valid_d  = flag_valid_q;
      state_d       = state_q;
      cnt_d         = cnt_q;
      redirect_d    = 1'b0;
      flush_d       = 1'b0;
      redirect_pc_d = redirect_pc_q;

      // Capture wins over a coincident clear; flag_reg itself is never cleared.
      if (cmp_hit) begin
         flag_reg_d   = bus.comp_flag;
         flag_valid_d = 1'b1;
      end else if (bus.flag_clr) begin
         flag_valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (bus.br_valid && br_ready && taken) begin
               redirect_pc_d = bus.br_target;
               redirect_d    = 1'b1;
               flush_d       = 1'b1;
               state_d       = StRedirect;
            end
         end
         StRedirect: begin
            if (FLUSH_CYCLES > 1) begin
               cnt_d   = FlushLoad;
               flush_d = 1'b1;
               state_d = StFlush;
            end else begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StIdle;
            end else begin
               flush_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         flag_reg_q    <= 10'd0;
         flag_valid_q  <= 1'b0;
         redirect_q    <= 1'b0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         flag_reg_q    <= flag_reg_d;
         flag_valid_q  <= flag_valid_d;
         redirect_q    <= redirect_d;
         flush_q       <= flush_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign bus.br_ready    = br_ready;
   assign bus.flag_reg    = flag_reg_q;
   assign bus.flag_valid  = flag_valid_q;
   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.flush       = flush_q;

endmodule

// File: doc/cmp_branch_unit.md
Name: cmp_branch_unit

Overview:
- Sits directly downstream of the execute-stage ALU.
- Captures the 10-bit comparison flag vector that the ALU produces on a CMP into an architectural flag register.
- Resolves conditional branches against those flags, or against same-cycle bypassed flags, through a valid/ready handshake.
- On a taken branch, drives a one-cycle PC redirect followed by a fixed-length front-end flush.

Parameters:
- ADDR_W, 32, width of branch target / redirect PC.
- FLUSH_CYCLES, 2, number of cycles flush is held after redirect (1..15).
- CMP_OP, 4'b0111, ALU opcode value that updates the flag register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  ALU stage holds a valid instruction this cycle.
- alu_op  input  4  opcode of the ALU-stage instruction.
- comp_flag  input  10  ALU flags: [0] s_gt, [1] s_le, [2] s_ge, [3] s_lt, [4] u_gt, [5] u_le, [6] u_ge, [7] u_lt, [8] ne, [9] eq.
- flag_clr  input  1  synchronous clear of flag_valid (context switch).
- br_valid  input  1  branch request present.
- br_ready  output  1  branch request accepted when br_valid & br_ready.
- br_cond  input  4  0..9 select comp_flag bit, 10 always-taken, 11..15 never-taken.
- br_target  input  ADDR_W  branch target PC.
- flag_reg  output  10  stored flag vector.
- flag_valid  output  1  flag_reg holds flags from a completed CMP.
- redirect  output  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  output  ADDR_W  registered target, valid while redirect=1.
- flush  output  1  kill younger in-flight instructions.

Behaviour:
- Reset (async, rst_n=0): flag_reg=0, flag_valid=0, redirect=0, redirect_pc=0, flush=0, state=IDLE, flush counter=0. br_ready=0 while rst_n=0.
- Flag capture: on a clock edge with ex_valid=1 and alu_op==CMP_OP, flag_reg<=comp_flag and flag_valid<=1.
- flag_clr clears flag_valid; flag_reg is left unchanged. If flag_clr and a capture occur in the same cycle, the capture wins.
- Effective flags: when ex_valid & alu_op==CMP_OP, eff_flags=comp_flag (combinational bypass) and eff_ok=1. Otherwise eff_flags=flag_reg and eff_ok=flag_valid.
- Condition needs flags iff br_cond<=9.
- State IDLE:
  - br_ready = !needs_flags | eff_ok.
  - On accept, taken = (br_cond<=9) ? eff_flags[br_cond] : (br_cond==10).
  - Taken: redirect_pc<=br_target, go to REDIRECT.
  - Not taken: stay in IDLE with no output activity; back-to-back accepts are allowed.
  - br_valid with needs_flags & !eff_ok: br_ready=0 and the branch stalls. Upstream holds br_cond/br_target stable until accepted.
- State REDIRECT (exactly 1 cycle): redirect=1, flush=1, br_ready=0. Load counter=FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES==1, go straight to IDLE.
- State FLUSH: flush=1, br_ready=0. Decrement counter each cycle and go to IDLE when it reaches 0.
- Total flush high = FLUSH_CYCLES+0 cycles counting REDIRECT, i.e. exactly FLUSH_CYCLES cycles.
- Flag capture continues in every state; it is not blocked by flush (the flushed instruction kill is upstream's responsibility).
- Latency: accept edge -> redirect high on next cycle. Not-taken branches produce zero outputs.
- Reset asserted mid-REDIRECT/FLUSH aborts immediately: all outputs go to 0 asynchronously, and the block restarts in IDLE.
- All outputs are registered except br_ready, which is combinational from state, br_cond, flag_valid, ex_valid and alu_op.

Test Plan:
- Reset then br_valid=1, br_cond=9, no CMP ever -> br_ready stays 0 for 5 cycles and redirect never fires. Then ex_valid=1, alu_op=CMP_OP, comp_flag=10'h200 -> br_ready=1 the same cycle (bypass), redirect=1 next cycle with redirect_pc=br_target=32'h0000_1000.
- CMP with comp_flag=10'h10A (s_le, s_lt, ne), then branch br_cond=9 (eq) -> not taken, no redirect/flush. Next-cycle branch br_cond=3 -> taken, redirect 1 cycle, flush high exactly 2 cycles, br_ready=0 for those 2 cycles.
- br_cond=10, flag_valid=0 -> accepted immediately and taken. br_cond=13 -> accepted immediately, never taken.
- flag_clr=1 and a CMP in the same cycle with comp_flag=10'h2A5 -> flag_reg=10'h2A5, flag_valid=1. flag_clr alone next cycle -> flag_valid=0, flag_reg still 10'h2A5.
- Taken branch, then drive rst_n=0 during FLUSH's 2nd cycle -> flush, redirect, flag_valid drop to 0 without a clock edge. After release the block is in IDLE with br_ready=1 for br_cond=10.
- FLUSH_CYCLES=1 build: taken branch -> flush high exactly 1 cycle coincident with redirect. Back-to-back taken branches are separated by exactly 1 br_ready=0 cycle.
